regfile_write_buffer: RTL and testbench

//   Write buffer in front of the dual-write-port register RAM. Accepts one

---
 rtl/regfile_write_buffer_if.sv | 31 +++
 rtl/regfile_write_buffer.sv | 113 +++++++++++
 tb/tb_regfile_write_buffer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_buffer_if.sv
// Bundle of writeback-side request, hold/hazard-check and RAM write-port signals
// for the register-file write buffer.
interface regfile_write_buffer_if #(
    parameter int AW = 6,
    parameter int DW = 32
);
    logic          i_valid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_data;
    logic          o_ready;
    logic          i_hold;
    logic [AW-1:0] i_chk_addr;
    logic          o_chk_hit;
    logic          o_wen;
    logic [AW-1:0] o_wr_addr_a;
    logic [AW-1:0] o_wr_addr_b;
    logic [DW-1:0] o_wr_data_a;
    logic [DW-1:0] o_wr_data_b;

    modport slave (
        input  i_valid, i_addr, i_data, i_hold, i_chk_addr,
        output o_ready, o_chk_hit, o_wen,
        output o_wr_addr_a, o_wr_addr_b, o_wr_data_a, o_wr_data_b
    );

    modport master (
        output i_valid, i_addr, i_data, i_hold, i_chk_addr,
        input  o_ready, o_chk_hit, o_wen,
        input  o_wr_addr_a, o_wr_addr_b, o_wr_data_a, o_wr_data_b
    );
endinterface

// File: rtl/regfile_write_buffer.sv
// Small FIFO of register writes drained in pairs onto a dual-write-port RAM,
// with same-address coalescing and a combinational read-hazard check.
module regfile_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    regfile_write_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, nxt_ptr;
    logic [CW-1:0] count_q, count_d, pops;
    logic          push, ready;
    logic          wen_q, wen_d;
    logic [AW-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [DW-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
    logic [DEPTH-1:0] entry_hit;

    assign ready   = (count_q < CW'(DEPTH));
    assign push    = bus.i_valid && ready;
    assign nxt_ptr = rd_ptr_q + PW'(1);

    always_comb begin
        pops     = '0;
        wen_d    = 1'b0;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        if (!bus.i_hold && count_q != '0) begin
            wen_d = 1'b1;
            if (count_q == CW'(1)) begin
                pops     = CW'(1);
                addr_a_d = addr_mem[rd_ptr_q];
                addr_b_d = addr_mem[rd_ptr_q];
                data_a_d = data_mem[rd_ptr_q];
                data_b_d = data_mem[rd_ptr_q];
            end else if (addr_mem[nxt_ptr] == addr_mem[rd_ptr_q]) begin
                // Younger write to the same register wins; both ports carry it.
                pops     = CW'(2);
                addr_a_d = addr_mem[nxt_ptr];
                addr_b_d = addr_mem[nxt_ptr];
                data_a_d = data_mem[nxt_ptr];
                data_b_d = data_mem[nxt_ptr];
            end else begin
                pops     = CW'(2);
                addr_a_d = addr_mem[rd_ptr_q];
                addr_b_d = addr_mem[nxt_ptr];
                data_a_d = data_mem[rd_ptr_q];
                data_b_d = data_mem[nxt_ptr];
            end
        end
        count_d  = count_q + CW'(push) - pops;
        rd_ptr_d = rd_ptr_q + pops[PW-1:0];
        wr_ptr_d = wr_ptr_q + PW'(push);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            wen_q    <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            wen_q    <= wen_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
        end
    end

    // Storage needs no reset: occupancy is tracked solely by count/pointers.
    always_ff @(posedge i_clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= bus.i_addr;
            data_mem[wr_ptr_q] <= bus.i_data;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            logic [PW-1:0] offset;
            assign offset        = PW'(gi) - rd_ptr_q;
            assign entry_hit[gi] = ({1'b0, offset} < count_q) &&
                                   (addr_mem[gi] == bus.i_chk_addr);
        end
    endgenerate

    assign bus.o_ready     = ready;
    assign bus.o_chk_hit   = (|entry_hit) ||
                             (wen_q && (bus.i_chk_addr == addr_a_q ||
                                        bus.i_chk_addr == addr_b_q));
    assign bus.o_wen       = wen_q;
    assign bus.o_wr_addr_a = addr_a_q;
    assign bus.o_wr_addr_b = addr_b_q;
    assign bus.o_wr_data_a = data_a_q;
    assign bus.o_wr_data_b = data_b_q;
endmodule

// File: tb/tb_regfile_write_buffer.sv
// Directed bench for regfile_write_buffer: pairing, coalescing, full/ready,
// hazard check and asynchronous reset mid-operation.
module tb_regfile_write_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    regfile_write_buffer_if #(.AW(6), .DW(32)) bus ();

    regfile_write_buffer #(.DEPTH(4), .AW(6), .DW(32)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [76:0] beat();
        return {bus.o_wen, bus.o_wr_addr_a, bus.o_wr_addr_b, bus.o_wr_data_a, bus.o_wr_data_b};
    endfunction

    task automatic push(input logic [5:0] a, input logic [31:0] d);
        bus.i_valid = 1'b1;
        bus.i_addr  = a;
        bus.i_data  = d;
        tick();
        bus.i_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_valid = 1'b0; bus.i_addr = '0; bus.i_data = '0;
        bus.i_hold = 1'b0; bus.i_chk_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (beat() !== 77'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", beat()); end
        checks++;
        if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
        checks++;
        if (bus.o_chk_hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", bus.o_chk_hit); end
        rst = 1'b0;
        tick();
        $display("test_reset: outputs cleared");
    endtask

    task automatic test_single();
        push(6'd3, 32'hAAAA0001);
        checks++;
        if (bus.o_wen !== 1'b0) begin failures++; $display("FAIL single_latency wen got=%b exp=0", bus.o_wen); end
        tick();
        checks++;
        if (beat() !== {1'b1, 6'd3, 6'd3, 32'hAAAA0001, 32'hAAAA0001})
            begin failures++; $display("FAIL single_beat got=%h exp=%h", beat(), {1'b1, 6'd3, 6'd3, 32'hAAAA0001, 32'hAAAA0001}); end
        $display("single beat: a=%0d/%h b=%0d/%h", bus.o_wr_addr_a, bus.o_wr_data_a, bus.o_wr_addr_b, bus.o_wr_data_b);
        tick();
        checks++;
        if (beat() !== {1'b0, 6'd3, 6'd3, 32'hAAAA0001, 32'hAAAA0001})
            begin failures++; $display("FAIL single_idle_hold got=%h", beat()); end
    endtask

    // Queued under hold so the first beat sees two entries and pairs them.
    task automatic test_pair();
        bus.i_hold = 1'b1;
        push(6'd1, 32'h11);
        push(6'd2, 32'h22);
        push(6'd3, 32'h33);
        bus.i_hold = 1'b0;
        tick();
        checks++;
        if (beat() !== {1'b1, 6'd1, 6'd2, 32'h11, 32'h22})
            begin failures++; $display("FAIL pair_beat1 got=%h exp=%h", beat(), {1'b1, 6'd1, 6'd2, 32'h11, 32'h22}); end
        $display("pair beat1: a=%0d b=%0d", bus.o_wr_addr_a, bus.o_wr_addr_b);
        tick();
        checks++;
        if (beat() !== {1'b1, 6'd3, 6'd3, 32'h33, 32'h33})
            begin failures++; $display("FAIL pair_beat2 got=%h exp=%h", beat(), {1'b1, 6'd3, 6'd3, 32'h33, 32'h33}); end
        $display("pair beat2: a=%0d b=%0d", bus.o_wr_addr_a, bus.o_wr_addr_b);
        tick();
        checks++;
        if (bus.o_wen !== 1'b0) begin failures++; $display("FAIL pair_done wen got=%b exp=0", bus.o_wen); end
    endtask

    task automatic test_full();
        bus.i_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(6'(10 + i), 32'h100 + 32'(i));
            checks++;
            if (bus.o_ready !== (i < 3)) begin failures++; $display("FAIL full_ready_%0d got=%b exp=%b", i, bus.o_ready, (i < 3)); end
        end
        push(6'd14, 32'h104);
        checks++;
        if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL full_fifth_ready got=%b exp=0", bus.o_ready); end
        bus.i_hold = 1'b0;
        tick();
        checks++;
        if (beat() !== {1'b1, 6'd10, 6'd11, 32'h100, 32'h101})
            begin failures++; $display("FAIL full_beat1 got=%h", beat()); end
        checks++;
        if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL full_ready_rise got=%b exp=1", bus.o_ready); end
        tick();
        checks++;
        if (beat() !== {1'b1, 6'd12, 6'd13, 32'h102, 32'h103})
            begin failures++; $display("FAIL full_beat2 got=%h", beat()); end
        tick();
        checks++;
        if (bus.o_wen !== 1'b0) begin failures++; $display("FAIL full_no_fifth wen got=%b exp=0", bus.o_wen); end
        $display("full: drained 4 entries, 5th refused");
    endtask

    task automatic test_coalesce();
        bus.i_hold = 1'b1;
        push(6'd5, 32'h50);
        push(6'd5, 32'h51);
        bus.i_hold = 1'b0;
        tick();
        checks++;
        if (beat() !== {1'b1, 6'd5, 6'd5, 32'h51, 32'h51})
            begin failures++; $display("FAIL coalesce_beat got=%h", beat()); end
        $display("coalesce beat: a=%0d/%h b=%0d/%h", bus.o_wr_addr_a, bus.o_wr_data_a, bus.o_wr_addr_b, bus.o_wr_data_b);
        tick();
        checks++;
        if (bus.o_wen !== 1'b0) begin failures++; $display("FAIL coalesce_single wen got=%b exp=0", bus.o_wen); end
    endtask

    task automatic test_hazard();
        bus.i_chk_addr = 6'd9;
        #1;
        checks++;
        if (bus.o_chk_hit !== 1'b0) begin failures++; $display("FAIL hazard_before got=%b exp=0", bus.o_chk_hit); end
        push(6'd9, 32'h99);
        checks++;
        if (bus.o_chk_hit !== 1'b1) begin failures++; $display("FAIL hazard_queued got=%b exp=1", bus.o_chk_hit); end
        tick();
        checks++;
        if ({bus.o_wen, bus.o_chk_hit} !== 2'b11) begin failures++; $display("FAIL hazard_beat got=%b exp=11", {bus.o_wen, bus.o_chk_hit}); end
        tick();
        checks++;
        if (bus.o_chk_hit !== 1'b0) begin failures++; $display("FAIL hazard_after got=%b exp=0", bus.o_chk_hit); end
        bus.i_chk_addr = 6'd10;
        push(6'd9, 32'h98);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.o_chk_hit !== 1'b0) begin failures++; $display("FAIL hazard_other_%0d got=%b exp=0", i, bus.o_chk_hit); end
            tick();
        end
        $display("hazard: hit tracked addr 9 through queue and beat");
    endtask

    task automatic test_reset_mid();
        bus.i_hold = 1'b1;
        push(6'd20, 32'h200);
        push(6'd21, 32'h201);
        push(6'd22, 32'h202);
        bus.i_chk_addr = 6'd22;
        #1;
        checks++;
        if (bus.o_chk_hit !== 1'b1) begin failures++; $display("FAIL rstmid_queued_hit got=%b exp=1", bus.o_chk_hit); end
        bus.i_hold = 1'b0;
        tick();
        bus.i_hold = 1'b1;
        checks++;
        if (bus.o_wen !== 1'b1) begin failures++; $display("FAIL rstmid_wen_before got=%b exp=1", bus.o_wen); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_wen, bus.o_ready, bus.o_chk_hit} !== 3'b010)
            begin failures++; $display("FAIL rstmid_immediate got=%b exp=010", {bus.o_wen, bus.o_ready, bus.o_chk_hit}); end
        checks++;
        if (beat() !== 77'd0) begin failures++; $display("FAIL rstmid_outputs got=%h exp=0", beat()); end
        tick();
        rst = 1'b0;
        bus.i_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.o_wen !== 1'b0) begin failures++; $display("FAIL rstmid_no_write_%0d got=%b exp=0", i, bus.o_wen); end
        end
        $display("reset_mid: queue dropped");
    endtask

    initial begin
        test_reset();
        test_single();
        test_pair();
        test_full();
        test_coalesce();
        test_hazard();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
